shift_iter: RTL and testbench

SHIFT_ITER -- requirements
Module: shift_iter

---
 rtl/shift_iter.sv | 101 ++++++++++
 tb/tb_shift_iter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_iter.sv
// Iterative barrel-shifter replacement: shifts the operand one bit per clock
// (LSL/LSR/ASR/ROL) behind a valid/ready handshake on both sides.
module shift_iter #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] step;

  // ASR keeps the MSB in place each step, so it always refills with the
  // sign bit of the operand as originally accepted.
  always_comb begin
    step = work_q;
    case (op_q)
      OP_LSL:  step = {work_q[WIDTH-2:0], 1'b0};
      OP_LSR:  step = {1'b0, work_q[WIDTH-1:1]};
      OP_ASR:  step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = in_amt;
          op_d    = in_op;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          work_d = step;
          cnt_d  = cnt_q - {{(AW-1){1'b0}}, 1'b1};
        end else begin
          res_d   = work_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = res_q;

endmodule

// File: tb/tb_shift_iter.sv
// Scoreboard bench for shift_iter: stimulus pushes expected result and
// expected out_valid rise edge; a negedge monitor pops and compares.
module tb_shift_iter;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    int         riseEdge;
  } expect_t;

  expect_t scoreQ[$];
  int      cycleCnt = 0;
  int      checks   = 0;
  int      errors   = 0;
  logic    prevValid = 1'b0;

  shift_iter #(.WIDTH(8), .AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Each rising out_valid must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && out_valid && !prevValid) begin
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected out_valid", 32'd1, 32'd0);
      end else begin
        expect_t e;
        e = scoreQ.pop_front();
        checkOutput("result data", {24'd0, out_data}, {24'd0, e.data});
        checkOutput("result latency edge", cycleCnt, e.riseEdge);
      end
    end
    prevValid <= out_valid;
  end

  task automatic applyStimulus(input logic [7:0] data, input logic [2:0] amt,
                               input logic [1:0] op, input logic [7:0] expected,
                               input bit doPush);
    int budget;
    expect_t e;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) checkOutput("in_ready timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    in_amt   = amt;
    in_op    = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~data;
    in_amt   = ~amt;
    in_op    = ~op;
    checkOutput("busy after accept", {31'd0, busy}, 32'd1);
    if (doPush) begin
      e.data     = expected;
      e.riseEdge = cycleCnt + int'(amt) + 1;
      scoreQ.push_back(e);
    end
  endtask

  task automatic waitValid(input string name);
    int budget;
    budget = 0;
    while (!out_valid && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (!out_valid) checkOutput(name, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    expect_t e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 3'd0;
    in_op     = 2'b00;
    out_ready = 1'b1;
    #2;
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset out_data", {24'd0, out_data}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(8'hA5, 3'd3, LSL, 8'h28, 1'b1);
    waitValid("wait LSL");
    applyStimulus(8'h90, 3'd7, ASR, 8'hFF, 1'b1);
    checkOutput("out_data held in SHIFT", {24'd0, out_data}, 32'h28);
    waitValid("wait ASR");
    applyStimulus(8'h90, 3'd4, LSR, 8'h09, 1'b1);
    applyStimulus(8'h81, 3'd1, ROL, 8'h03, 1'b1);
    applyStimulus(8'h5C, 3'd0, LSL, 8'h5C, 1'b1);
    applyStimulus(8'h5C, 3'd0, LSR, 8'h5C, 1'b1);
    applyStimulus(8'h5C, 3'd0, ASR, 8'h5C, 1'b1);
    applyStimulus(8'h5C, 3'd0, ROL, 8'h5C, 1'b1);
    applyStimulus(8'h70, 3'd2, ASR, 8'h1C, 1'b1);
    applyStimulus(8'hFF, 3'd7, LSR, 8'h01, 1'b1);
    applyStimulus(8'h01, 3'd7, LSL, 8'h80, 1'b1);
    applyStimulus(8'h81, 3'd7, ROL, 8'hC0, 1'b1);
    waitValid("wait ROL7");

    // Consumer stalls while upstream keeps offering a new request.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(8'hA5, 3'd4, ROL, 8'h5A, 1'b1);
    waitValid("wait stall result");
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_amt   = 3'd2;
    in_op    = LSL;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall out_data", {24'd0, out_data}, 32'h5A);
      checkOutput("stall in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("stall out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    in_data   = 8'h5C;
    in_amt    = 3'd0;
    in_op     = ROL;
    @(posedge clk);
    #1;
    checkOutput("post-handshake in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("post-handshake out_valid", {31'd0, out_valid}, 32'd0);
    e.data     = 8'h5C;
    e.riseEdge = cycleCnt + 2;
    scoreQ.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("accept after handshake busy", {31'd0, busy}, 32'd1);
    waitValid("wait post-stall result");

    // Abort mid-SHIFT: no result may appear, outputs clear without a clock.
    applyStimulus(8'h3C, 3'd6, LSL, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort out_data", {24'd0, out_data}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort held busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(8'h81, 3'd1, ROL, 8'h03, 1'b1);
    waitValid("wait after reset");

    repeat (10) @(negedge clk);
    checkOutput("scoreboard drained", scoreQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
